clb_rk_reverse_buf: RTL and testbench

//  Round-key reversal buffer for the clb_ecb decryption path. The forward key

---
 rtl/clb_rk_reverse_buf_if.sv | 27 ++
 rtl/clb_rk_reverse_buf.sv | 155 +++++++++++++++
 tb/tb_clb_rk_reverse_buf.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/clb_rk_reverse_buf_if.sv
// Round-key reversal buffer bus: forward key load, reversed key replay, status.
interface clb_rk_reverse_buf_if #(
    parameter int unsigned RK_W = 128
) ();
    logic            clear;
    logic            rk_valid;
    logic [RK_W-1:0] rk_in;
    logic            rk_last;
    logic            rd_req;
    logic            rd_valid;
    logic [RK_W-1:0] rd_key;
    logic            rd_last;
    logic            key_ready;
    logic            err;

    // Driver of the key schedule and of replay requests.
    modport master (
        output clear, rk_valid, rk_in, rk_last, rd_req,
        input  rd_valid, rd_key, rd_last, key_ready, err
    );

    // The reversal buffer itself.
    modport slave (
        input  clear, rk_valid, rk_in, rk_last, rd_req,
        output rd_valid, rd_key, rd_last, key_ready, err
    );
endinterface

// File: rtl/clb_rk_reverse_buf.sv
// Captures forward round keys RK0..RK(N-1) and replays them RK(N-1)..RK0 on request.
module clb_rk_reverse_buf #(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned RK_W   = 128,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    clb_rk_reverse_buf_if.slave   bus
);
    localparam int unsigned AW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2,
        REPLAY = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  rptr_q, rptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [RK_W-1:0]   rd_key_q, rd_key_d;
    logic              rd_last_q, rd_last_d;
    logic              key_ready_q, key_ready_d;
    logic              err_q, err_d;

    logic [RK_W-1:0]   mem_q [ROUNDS];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     rd_idx;

    assign rd_idx = AW'(rptr_q);

    // Next-state, pointer, write-port and output computation.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_key_d   = rd_key_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = AW'(wptr_q);

        if (bus.clear) begin
            state_d = IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.rk_valid) begin
                        mem_we = 1'b1;
                        if (wptr_q == LAST_PTR) begin
                            // N-th key must carry rk_last; otherwise the load is too long.
                            state_d = bus.rk_last ? READY : IDLE;
                            err_d   = err_q | ~bus.rk_last;
                            wptr_d  = '0;
                        end else if (bus.rk_last) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                            wptr_d  = '0;
                        end else begin
                            wptr_d = wptr_q + CNT_W'(1);
                        end
                    end
                end
                READY, REPLAY: begin
                    if (bus.rk_valid) begin
                        // A new schedule wins over any replay request.
                        if (bus.rk_last) begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = '0;
                            wptr_d    = CNT_W'(1);
                            state_d   = LOAD;
                        end
                    end else if (bus.rd_req) begin
                        rd_valid_d = 1'b1;
                        if (state_q == READY) begin
                            rd_key_d = mem_q[AW'(ROUNDS - 1)];
                            rptr_d   = LAST_PTR - CNT_W'(1);
                            state_d  = REPLAY;
                        end else begin
                            rd_key_d = mem_q[rd_idx];
                            if (rptr_q == '0) begin
                                rd_last_d = 1'b1;
                                state_d   = READY;
                            end else begin
                                rptr_d = rptr_q - CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (bus.rk_valid) begin
                        if (bus.rk_last) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = '0;
                            wptr_d    = CNT_W'(1);
                            state_d   = LOAD;
                        end
                    end
                end
            endcase
        end

        key_ready_d = (state_d == READY) || (state_d == REPLAY);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_key_q    <= '0;
            rd_last_q   <= 1'b0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_key_q    <= rd_key_d;
            rd_last_q   <= rd_last_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
        end
    end

    // Round-key storage; contents are only meaningful once a load completes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= bus.rk_in;
        end
    end

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_key    = rd_key_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.key_ready = key_ready_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_clb_rk_reverse_buf.sv
// Bench for the round-key reversal buffer: reference keeps the loaded schedule as an array.
module tb_clb_rk_reverse_buf;
    localparam int unsigned ROUNDS = 32;
    localparam int unsigned RK_W   = 128;
    localparam int unsigned CNT_W  = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clb_rk_reverse_buf_if #(.RK_W(RK_W)) bus ();

    clb_rk_reverse_buf #(.ROUNDS(ROUNDS), .RK_W(RK_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [RK_W-1:0] ref_keys [ROUNDS];
    logic [RK_W-1:0] new_keys [ROUNDS];

    function automatic logic [RK_W-1:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        bus.clear    = 1'b0;
        bus.rk_valid = 1'b0;
        bus.rk_in    = '0;
        bus.rk_last  = 1'b0;
        bus.rd_req   = 1'b0;
    endtask

    task automatic send_key(input logic [RK_W-1:0] k, input logic last);
        bus.rk_valid = 1'b1;
        bus.rk_in    = k;
        bus.rk_last  = last;
        @(negedge clk);
        bus.rk_valid = 1'b0;
        bus.rk_last  = 1'b0;
    endtask

    // Loads new_keys as a complete schedule; the model remembers it.
    task automatic load_staged();
        for (int i = 0; i < ROUNDS; i++) send_key(new_keys[i], i == ROUNDS - 1);
        for (int i = 0; i < ROUNDS; i++) ref_keys[i] = new_keys[i];
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_key !== '0)      begin n_bad++; $display("FAIL reset_rd_key got %h want 0", bus.rd_key); end
        n_cmp++; if (bus.rd_last !== 1'b0)   begin n_bad++; $display("FAIL reset_rd_last got %b want 0", bus.rd_last); end
        n_cmp++; if (bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_key_ready got %b want 0", bus.key_ready); end
        n_cmp++; if (bus.err !== 1'b0)       begin n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < ROUNDS; i++) new_keys[i] = rand_key();
        load_staged();
        n_cmp++; if (bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_load_key_ready got %b want 1", bus.key_ready); end
        bus.rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1-k]) begin
                n_bad++; $display("FAIL rst_pre_key%0d got v=%b %h want v=1 %h", k, bus.rd_valid, bus.rd_key, ref_keys[ROUNDS-1-k]);
            end
        end
        bus.rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_key !== '0 || bus.rd_last !== 1'b0 || bus.key_ready !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL midreplay_reset got v=%b k=%h l=%b r=%b e=%b want all 0", bus.rd_valid, bus.rd_key, bus.rd_last, bus.key_ready, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL post_reset_req got v=%b r=%b want 0 0", bus.rd_valid, bus.key_ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < ROUNDS; i++) new_keys[i] = RK_W'(i);
        load_staged();
        n_cmp++; if (bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_key_ready got %b want 1", bus.key_ready); end
        bus.rd_req = 1'b1;
        for (int k = 0; k < ROUNDS; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1-k] || bus.rd_last !== (k == ROUNDS - 1)) begin
                n_bad++; $display("FAIL b2b_key%0d got v=%b k=%0d l=%b want v=1 k=%0d l=%b", k, bus.rd_valid, bus.rd_key, bus.rd_last, ref_keys[ROUNDS-1-k], (k == ROUNDS - 1));
            end
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.key_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_after got v=%b r=%b want 0 1", bus.rd_valid, bus.key_ready); end
    endtask

    task automatic test_replay_twice();
        for (int i = 0; i < ROUNDS; i++) new_keys[i] = rand_key();
        load_staged();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < ROUNDS; k++) begin
                bus.rd_req = 1'b1;
                @(negedge clk);
                bus.rd_req = 1'b0;
                n_cmp++;
                if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1-k] || bus.rd_last !== (k == ROUNDS - 1)) begin
                    n_bad++; $display("FAIL twice_p%0d_key%0d got v=%b k=%h l=%b want v=1 k=%h", pass, k, bus.rd_valid, bus.rd_key, bus.rd_last, ref_keys[ROUNDS-1-k]);
                end
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    n_cmp++;
                    if (bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_key !== ref_keys[ROUNDS-1-k]) begin
                        n_bad++; $display("FAIL twice_gap_p%0d_k%0d got v=%b l=%b k=%h want v=0 l=0 k=%h", pass, k, bus.rd_valid, bus.rd_last, bus.rd_key, ref_keys[ROUNDS-1-k]);
                    end
                end
            end
        end
    endtask

    task automatic test_short_load();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        for (int i = 0; i < 5; i++) send_key(rand_key(), i == 4);
        n_cmp++; if (bus.err !== 1'b1 || bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL short_err got e=%b r=%b want 1 0", bus.err, bus.key_ready); end
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL short_idle_req got v=%b want 0", bus.rd_valid); end
        for (int i = 0; i < ROUNDS; i++) new_keys[i] = rand_key();
        load_staged();
        n_cmp++; if (bus.key_ready !== 1'b1 || bus.err !== 1'b1) begin n_bad++; $display("FAIL short_reload got r=%b e=%b want 1 1", bus.key_ready, bus.err); end
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1]) begin n_bad++; $display("FAIL short_reload_key got v=%b k=%h want v=1 k=%h", bus.rd_valid, bus.rd_key, ref_keys[ROUNDS-1]); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_cmp++; if (bus.err !== 1'b0 || bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL short_clear got e=%b r=%b want 0 0", bus.err, bus.key_ready); end
    endtask

    task automatic test_abort_reload();
        for (int i = 0; i < ROUNDS; i++) new_keys[i] = RK_W'(i);
        load_staged();
        bus.rd_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1-k]) begin
                n_bad++; $display("FAIL abort_pre_key%0d got v=%b k=%0d want v=1 k=%0d", k, bus.rd_valid, bus.rd_key, ref_keys[ROUNDS-1-k]);
            end
        end
        for (int i = 0; i < ROUNDS; i++) new_keys[i] = RK_W'(i + 100);
        bus.rk_valid = 1'b1;
        bus.rk_in    = new_keys[0];
        bus.rk_last  = 1'b0;
        @(negedge clk);
        bus.rd_req   = 1'b0;
        bus.rk_valid = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL abort_collide got v=%b r=%b want 0 0", bus.rd_valid, bus.key_ready); end
        for (int i = 1; i < ROUNDS; i++) send_key(new_keys[i], i == ROUNDS - 1);
        for (int i = 0; i < ROUNDS; i++) ref_keys[i] = new_keys[i];
        n_cmp++; if (bus.key_ready !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL abort_reload_ready got r=%b e=%b want 1 0", bus.key_ready, bus.err); end
        bus.rd_req = 1'b1;
        for (int k = 0; k < ROUNDS; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_key !== ref_keys[ROUNDS-1-k] || bus.rd_last !== (k == ROUNDS - 1)) begin
                n_bad++; $display("FAIL abort_new_key%0d got v=%b k=%0d l=%b want v=1 k=%0d", k, bus.rd_valid, bus.rd_key, bus.rd_last, ref_keys[ROUNDS-1-k]);
            end
        end
        bus.rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_long_load();
        for (int i = 0; i < ROUNDS; i++) send_key(rand_key(), 1'b0);
        n_cmp++; if (bus.err !== 1'b1 || bus.key_ready !== 1'b0) begin n_bad++; $display("FAIL long_err got e=%b r=%b want 1 0", bus.err, bus.key_ready); end
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL long_idle_req got v=%b want 0", bus.rd_valid); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL long_clear got e=%b want 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_replay_twice();
        test_short_load();
        test_abort_reload();
        test_long_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
